// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART echo block.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Clocks per bit, integer division.
    function automatic int baud_ticks(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Width needed to index/count n values; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1-style serial transmitter. The line is driven straight from a flop.
//
// state    | meaning
// TX_IDLE  | line high, waiting for tx_load
// TX_START | start bit (low) for one bit time
// TX_DATA  | payload bits, LSB first
// TX_STOP  | stop bit(s) high
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [PAYLOAD_BITS-1:0] tx_data,
    input  logic                    tx_load,
    output logic                    tx_busy,
    output logic                    uart_txd
);

    localparam int BAUD_TICKS = baud_ticks(CLK_HZ, BIT_RATE);
    localparam int CNT_W      = idx_width(BAUD_TICKS);
    localparam int BIT_W      = idx_width(PAYLOAD_BITS);
    localparam int STOP_W     = idx_width(STOP_BITS);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    tx_state_t                 state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [BIT_W-1:0]          bit_idx;
    logic [STOP_W-1:0]         stop_idx;
    logic [PAYLOAD_BITS-1:0]   shreg;
    logic                      tick;
    logic                      txd_nxt;

    assign tick = (cnt == '0);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= TX_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode; each phase ends on the bit-timer terminal count.
    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:  if (tx_load) state_nxt = TX_START;
            TX_START: if (tick) state_nxt = TX_DATA;
            TX_DATA:  if (tick && bit_idx == BIT_LAST) state_nxt = TX_STOP;
            TX_STOP:  if (tick && stop_idx == STOP_LAST) state_nxt = TX_IDLE;
            default:  state_nxt = TX_IDLE;
        endcase
    end

    // Output decode: busy flag and the line level for the next bit.
    always_comb begin
        tx_busy = (state != TX_IDLE);
        txd_nxt = uart_txd;
        case (state)
            TX_IDLE:  txd_nxt = !tx_load;
            TX_START: if (tick) txd_nxt = shreg[0];
            TX_DATA:  if (tick) txd_nxt = (bit_idx == BIT_LAST) ? 1'b1 : shreg[0];
            TX_STOP:  txd_nxt = 1'b1;
            default:  txd_nxt = 1'b1;
        endcase
    end

    // Bit timer, shift register and registered line driver.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= '0;
            shreg    <= '0;
            uart_txd <= 1'b1;
        end else begin
            uart_txd <= txd_nxt;
            case (state)
                TX_IDLE: begin
                    if (tx_load) begin
                        shreg <= tx_data;
                        cnt   <= BAUD_LAST;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        shreg   <= shreg >> 1;
                        cnt     <= BAUD_LAST;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        cnt <= BAUD_LAST;
                        if (bit_idx == BIT_LAST) begin
                            stop_idx <= '0;
                        end else begin
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (stop_idx != STOP_LAST) begin
                            stop_idx <= stop_idx + 1'b1;
                            cnt      <= BAUD_LAST;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_top.sv
// UART loopback: receive frames on uart_rxd, echo them on uart_txd,
// show the last good byte on led_out. Optional macro UART_FRAMING_CHECK_EN
// discards frames whose stop-bit samples are low.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | half-bit wait, then confirm the start bit is still low
// RX_DATA  | mid-bit sampling of the payload, LSB first
// RX_STOP  | mid-bit stop sample(s), then half-bit tail to frame end
module uart_echo_top
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    output logic                    uart_txd,
    output logic [PAYLOAD_BITS-1:0] led_out
);

    localparam int BAUD_TICKS = baud_ticks(CLK_HZ, BIT_RATE);
    localparam int HALF_TICKS = BAUD_TICKS / 2;
    localparam int CNT_W      = idx_width(BAUD_TICKS);
    localparam int BIT_W      = idx_width(PAYLOAD_BITS);
    localparam int STOP_W     = idx_width(STOP_BITS);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_TICKS - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    logic                    rx_s1, rx_s2, rx_prev, rx_fall;
    rx_state_t               rx_state, rx_state_nxt;
    logic [CNT_W-1:0]        rx_cnt;
    logic [BIT_W-1:0]        rx_bit_idx;
    logic [STOP_W-1:0]       rx_stop_idx;
    logic                    rx_tail;
    logic [PAYLOAD_BITS-1:0] rx_shreg;
    logic                    rx_tick, rx_done_ok, rx_valid, rx_break;
`ifdef UART_FRAMING_CHECK_EN
    logic                    rx_ferr;
`endif
    logic                    hold_full;
    logic [PAYLOAD_BITS-1:0] hold_data;
    logic                    tx_load, tx_busy;
    logic [PAYLOAD_BITS-1:0] tx_data;

    // Two-flop synchronizer plus a delayed copy for edge detection; idle high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_tick = (rx_cnt == '0);

    // RX state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rx_state <= RX_IDLE;
        else         rx_state <= rx_state_nxt;
    end

    // RX next-state decode; a start bit that is high again at mid-bit is a glitch.
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
            RX_START: if (rx_tick) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit_idx == BIT_LAST) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_tick && rx_tail) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    // RX output decode: frame completion, gated by the framing check when enabled.
    always_comb begin
        rx_done_ok = (rx_state == RX_STOP) && rx_tick && rx_tail;
`ifdef UART_FRAMING_CHECK_EN
        if (rx_ferr) rx_done_ok = 1'b0;
`endif
    end

    // RX bit timer, sampling shift register and completion pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_cnt      <= '0;
            rx_bit_idx  <= '0;
            rx_stop_idx <= '0;
            rx_tail     <= 1'b0;
            rx_shreg    <= '0;
            rx_valid    <= 1'b0;
`ifdef UART_FRAMING_CHECK_EN
            rx_ferr     <= 1'b0;
`endif
        end else begin
            rx_valid <= rx_done_ok;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) rx_cnt <= HALF_LAST;
                end
                RX_START: begin
                    if (rx_tick) begin
                        rx_cnt     <= BAUD_LAST;
                        rx_bit_idx <= '0;
`ifdef UART_FRAMING_CHECK_EN
                        rx_ferr    <= 1'b0;
`endif
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shreg    <= PAYLOAD_BITS'({rx_s2, rx_shreg} >> 1);
                        rx_bit_idx  <= rx_bit_idx + 1'b1;
                        rx_cnt      <= BAUD_LAST;
                        rx_stop_idx <= '0;
                        rx_tail     <= 1'b0;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        if (rx_tail) begin
                            rx_tail <= 1'b0;
                        end else begin
`ifdef UART_FRAMING_CHECK_EN
                            if (!rx_s2) rx_ferr <= 1'b1;
`endif
                            if (rx_stop_idx == STOP_LAST) begin
                                rx_tail <= 1'b1;
                                rx_cnt  <= HALF_LAST;
                            end else begin
                                rx_stop_idx <= rx_stop_idx + 1'b1;
                                rx_cnt      <= BAUD_LAST;
                            end
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_cnt <= '0;
            endcase
        end
    end

    // rx_break flags a received 0x00; it is always a subset of rx_valid.
    assign rx_break = rx_valid && (rx_shreg == '0);

    // Older byte in the holding buffer always goes to TX first.
    assign tx_load = !tx_busy && (hold_full || rx_valid);
    assign tx_data = hold_full ? hold_data : rx_shreg;

    // LED register and one-entry holding buffer for bytes arriving while TX is busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_out   <= '0;
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            if (rx_valid || rx_break) led_out <= rx_shreg;
            if (hold_full && !tx_busy) begin
                if (rx_valid) hold_data <= rx_shreg;
                else          hold_full <= 1'b0;
            end else if (rx_valid && tx_busy && !hold_full) begin
                hold_data <= rx_shreg;
                hold_full <= 1'b1;
            end
        end
    end

    uart_tx #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .STOP_BITS    (STOP_BITS)
    ) u_tx (
        .clk      (clk),
        .resetn   (resetn),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_busy  (tx_busy),
        .uart_txd (uart_txd)
    );

endmodule

// File: tb/tb_uart_echo_top.sv
// Directed bench for uart_echo_top, run at 16 clocks per bit.
module tb_uart_echo_top;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 62_500;
    localparam int BAUD     = CLK_HZ / BIT_RATE;
    localparam int HALF     = BAUD / 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;
    logic [7:0] led_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_echo_top #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .led_out  (led_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stop_val);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = v[i];
            repeat (BAUD) @(negedge clk);
        end
        uart_rxd = stop_val;
        repeat (BAUD) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic capture(input string tag, output logic [7:0] b);
        logic seen;
        seen = 1'b0;
        b = 8'h00;
        for (int i = 0; i < 14 * BAUD; i++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_start_seen"}, seen, 1);
        if (seen) begin
            repeat (HALF) @(negedge clk);
            check({tag, "_start_bit"}, uart_txd, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                b[i] = uart_txd;
            end
            repeat (BAUD) @(negedge clk);
            check({tag, "_stop_bit"}, uart_txd, 1);
        end
    endtask

    task automatic echo_byte(input logic [7:0] v, input string tag);
        logic [7:0] got;
        send_frame(v, 1'b1);
        capture(tag, got);
        check({tag, "_data"}, got, v);
        repeat (HALF + 2) @(negedge clk);
        check({tag, "_led"}, led_out, v);
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        logic seen_low;
        seen_low = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) seen_low = 1'b1;
        end
        check(tag, seen_low, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] rb;
        logic [7:0] b2b_got [3];
        logic [7:0] b2b_exp [3];

        resetn   = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_led", led_out, 0);
        resetn = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        check("idle_txd", uart_txd, 1);
        check("idle_led", led_out, 0);

        echo_byte(8'h41, "b41");
        echo_byte(8'h5A, "b5a");
        echo_byte(8'h30, "b30");
        echo_byte(8'hFF, "bff");
        echo_byte(8'h01, "b01");

        // Quarter-bit low glitch must not start a frame.
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (BAUD / 4) @(negedge clk);
        uart_rxd = 1'b1;
        expect_silence("glitch_no_echo", 12 * BAUD);
        check("glitch_led", led_out, 8'h01);
        echo_byte(8'hAA, "glitch_aa");

        echo_byte(8'h00, "b00");

        // Receive while the previous echo is still on the wire.
        b2b_exp[0] = 8'h12;
        b2b_exp[1] = 8'h34;
        b2b_exp[2] = 8'h56;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    send_frame(b2b_exp[i], 1'b1);
                    repeat (BAUD / 4) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 3; i++) capture($sformatf("b2b%0d", i), b2b_got[i]);
            end
        join
        for (int i = 0; i < 3; i++) check($sformatf("b2b%0d_data", i), b2b_got[i], b2b_exp[i]);
        repeat (HALF + 2) @(negedge clk);
        check("b2b_led", led_out, 8'h56);

        for (int i = 0; i < 20; i++) begin
            rb = 8'($urandom_range(0, 255));
            echo_byte(rb, $sformatf("rand%0d", i));
            repeat (BAUD / 4) @(negedge clk);
        end
        echo_byte(8'h55, "b55");
        echo_byte(8'hAA, "baa");

        send_frame(8'h3C, 1'b0);
`ifdef UART_FRAMING_CHECK_EN
        expect_silence("ferr_no_echo", 12 * BAUD);
        check("ferr_led", led_out, 8'hAA);
`else
        capture("nofc", got);
        check("nofc_data", got, 8'h3C);
        repeat (HALF + 2) @(negedge clk);
        check("nofc_led", led_out, 8'h3C);
`endif

        // Reset about five bit times into a 0xDE frame.
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (BAUD) @(negedge clk);
        rb = 8'hDE;
        for (int i = 0; i < 4; i++) begin
            uart_rxd = rb[i];
            repeat (BAUD) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (HALF) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_txd", uart_txd, 1);
        check("midrst_led", led_out, 0);
        @(negedge clk);
        resetn = 1'b1;
        expect_silence("midrst_no_echo", 12 * BAUD);
        check("midrst_led_after", led_out, 0);
        echo_byte(8'hAD, "bad");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
